// File: rtl/alu_operand_stage_if.sv
// Operand-stage bus: upstream instruction handshake, ALU-side operand handshake
// and the ALU writeback port. The slave modport is the operand stage's view;
// the master modport is the surrounding pipeline (or bench) view.
interface alu_operand_stage_if #(
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned OPCODE_LENGTH = 5,
    parameter int unsigned ADDR_WIDTH    = 4
);
    // Upstream instruction
    logic                     in_valid;
    logic                     in_ready;
    logic [OPCODE_LENGTH-1:0] in_opcode;
    logic [ADDR_WIDTH-1:0]    in_rs1_addr;
    logic [ADDR_WIDTH-1:0]    in_rs2_addr;
    logic [ADDR_WIDTH-1:0]    in_rd_addr;
    logic                     in_use_imm;
    logic [DATA_WIDTH-1:0]    in_imm;

    // Toward the ALU
    logic                     out_valid;
    logic                     out_ready;
    logic [DATA_WIDTH-1:0]    rs1;
    logic [DATA_WIDTH-1:0]    rs2;
    logic [OPCODE_LENGTH-1:0] Opcode;
    logic [ADDR_WIDTH-1:0]    out_rd_addr;

    // ALU writeback
    logic                     wb_en;
    logic [ADDR_WIDTH-1:0]    wb_addr;
    logic [DATA_WIDTH-1:0]    wb_data;

    modport slave (
        input  in_valid, in_opcode, in_rs1_addr, in_rs2_addr, in_rd_addr, in_use_imm, in_imm,
        input  out_ready, wb_en, wb_addr, wb_data,
        output in_ready, out_valid, rs1, rs2, Opcode, out_rd_addr
    );

    modport master (
        output in_valid, in_opcode, in_rs1_addr, in_rs2_addr, in_rd_addr, in_use_imm, in_imm,
        output out_ready, wb_en, wb_addr, wb_data,
        input  in_ready, out_valid, rs1, rs2, Opcode, out_rd_addr
    );
endinterface

// File: rtl/alu_operand_stage.sv
// ALU operand/issue stage: register file, RAW scoreboard and a one-entry output
// register toward the ALU. Define FWD_BYPASS_EN to forward a same-cycle
// writeback into the operands; otherwise a matching writeback stalls one cycle.
module alu_operand_stage #(
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned OPCODE_LENGTH = 5,
    parameter int unsigned REG_COUNT     = 16,
    parameter int unsigned ADDR_WIDTH    = 4
) (
    input logic                clk,
    input logic                rst_n,
    alu_operand_stage_if.slave bus
);

    logic [DATA_WIDTH-1:0]    regfile_q [REG_COUNT];
    logic [DATA_WIDTH-1:0]    regfile_d [REG_COUNT];
    logic [REG_COUNT-1:0]     pending_q, pending_d;
    logic                     out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0]    rs1_q, rs1_d;
    logic [DATA_WIDTH-1:0]    rs2_q, rs2_d;
    logic [OPCODE_LENGTH-1:0] opcode_q, opcode_d;
    logic [ADDR_WIDTH-1:0]    rd_q, rd_d;

    logic                     wb_active;
    logic                     issue;
    logic                     accept;
    logic                     hazard;
    logic                     in_ready;
    logic [DATA_WIDTH-1:0]    rs1_val, rs2_val;

    // A source is blocked if its result is outstanding in the scoreboard (and not
    // retiring this cycle), or still sitting in the output register.
    function automatic logic src_pending(
        input logic [ADDR_WIDTH-1:0] addr,
        input logic [REG_COUNT-1:0]  pend,
        input logic                  wb_act,
        input logic [ADDR_WIDTH-1:0] wb_a,
        input logic                  inflight,
        input logic [ADDR_WIDTH-1:0] rd
    );
        logic p;
        p = 1'b0;
        if (addr != '0) begin
            p = pend[addr] && !(wb_act && (wb_a == addr));
            p = p || (inflight && (rd == addr));
`ifdef FWD_BYPASS_EN
`else
            // No bypass path: wait for the write to land in the register file.
            p = p || (wb_act && (wb_a == addr));
`endif
        end
        return p;
    endfunction

    // Handshake and hazard detection
    always_comb begin
        wb_active = bus.wb_en && (bus.wb_addr != '0);
        issue     = out_valid_q && bus.out_ready;
        hazard    = src_pending(bus.in_rs1_addr, pending_q, wb_active, bus.wb_addr,
                                out_valid_q, rd_q)
                 || (!bus.in_use_imm &&
                     src_pending(bus.in_rs2_addr, pending_q, wb_active, bus.wb_addr,
                                 out_valid_q, rd_q));
        in_ready  = !hazard && (!out_valid_q || bus.out_ready);
        accept    = bus.in_valid && in_ready;
    end

    // Operand read with r0 hardwired to zero and optional write-first bypass
    always_comb begin
        rs1_val = regfile_q[bus.in_rs1_addr];
        rs2_val = regfile_q[bus.in_rs2_addr];
`ifdef FWD_BYPASS_EN
        if (wb_active && (bus.wb_addr == bus.in_rs1_addr)) rs1_val = bus.wb_data;
        if (wb_active && (bus.wb_addr == bus.in_rs2_addr)) rs2_val = bus.wb_data;
`endif
        if (bus.in_rs1_addr == '0) rs1_val = '0;
        if (bus.in_rs2_addr == '0) rs2_val = '0;
        if (bus.in_use_imm)        rs2_val = bus.in_imm;
    end

    // Output register next state: load on accept, drop valid on issue, else hold
    always_comb begin
        out_valid_d = out_valid_q;
        rs1_d       = rs1_q;
        rs2_d       = rs2_q;
        opcode_d    = opcode_q;
        rd_d        = rd_q;
        if (accept) begin
            out_valid_d = 1'b1;
            rs1_d       = rs1_val;
            rs2_d       = rs2_val;
            opcode_d    = bus.in_opcode;
            rd_d        = bus.in_rd_addr;
        end else if (issue) begin
            out_valid_d = 1'b0;
        end
    end

    // Register file and scoreboard next state; set on issue overrides clear on writeback
    always_comb begin
        pending_d = pending_q;
        for (int i = 0; i < int'(REG_COUNT); i++) begin
            regfile_d[i] = regfile_q[i];
            if (wb_active && (bus.wb_addr == ADDR_WIDTH'(i))) begin
                regfile_d[i] = bus.wb_data;
                pending_d[i] = 1'b0;
            end
        end
        if (issue && (rd_q != '0)) pending_d[rd_q] = 1'b1;
    end

    // State registers, all cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(REG_COUNT); i++) regfile_q[i] <= '0;
            pending_q   <= '0;
            out_valid_q <= 1'b0;
            rs1_q       <= '0;
            rs2_q       <= '0;
            opcode_q    <= '0;
            rd_q        <= '0;
        end else begin
            for (int i = 0; i < int'(REG_COUNT); i++) regfile_q[i] <= regfile_d[i];
            pending_q   <= pending_d;
            out_valid_q <= out_valid_d;
            rs1_q       <= rs1_d;
            rs2_q       <= rs2_d;
            opcode_q    <= opcode_d;
            rd_q        <= rd_d;
        end
    end

    assign bus.in_ready    = in_ready;
    assign bus.out_valid   = out_valid_q;
    assign bus.rs1         = rs1_q;
    assign bus.rs2         = rs2_q;
    assign bus.Opcode      = opcode_q;
    assign bus.out_rd_addr = rd_q;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed bench for alu_operand_stage: reset, operand read, RAW stall and
// release, immediate mode, backpressure and mid-stream reset. FWD_BYPASS_EN
// selects the expected release cycle of the hazard sequence.
module tb_alu_operand_stage;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    alu_operand_stage_if bus ();

    alu_operand_stage dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [4:0] op, input logic [3:0] a1, input logic [3:0] a2,
                         input logic [3:0] rd, input logic imm_sel, input logic [31:0] imm);
        bus.in_valid    = 1'b1;
        bus.in_opcode   = op;
        bus.in_rs1_addr = a1;
        bus.in_rs2_addr = a2;
        bus.in_rd_addr  = rd;
        bus.in_use_imm  = imm_sel;
        bus.in_imm      = imm;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_opcode = '0;
        bus.in_rs1_addr = '0;
        bus.in_rs2_addr = '0;
        bus.in_rd_addr = '0;
        bus.in_use_imm = 1'b0;
        bus.in_imm = '0;
        bus.out_ready = 1'b1;
        bus.wb_en = 1'b0;
        bus.wb_addr = '0;
        bus.wb_data = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_rs1", bus.rs1, 32'd0);
        check("rst_rs2", bus.rs2, 32'd0);
        check("rst_opcode", 32'(bus.Opcode), 32'd0);
        check("rst_rd", 32'(bus.out_rd_addr), 32'd0);

        // ADD r1,r2 with zeroed register file
        drive(5'd1, 4'd1, 4'd2, 4'd0, 1'b0, 32'd0);
        #1 check("add0_ready", 32'(bus.in_ready), 32'd1);
        tick();
        bus.in_valid = 1'b0;
        check("add0_valid", 32'(bus.out_valid), 32'd1);
        check("add0_rs1", bus.rs1, 32'd0);
        check("add0_rs2", bus.rs2, 32'd0);
        check("add0_opcode", 32'(bus.Opcode), 32'd1);

        // Writeback r1=1, r2=2
        bus.wb_en = 1'b1; bus.wb_addr = 4'd1; bus.wb_data = 32'h1;
        tick();
        check("add0_drained", 32'(bus.out_valid), 32'd0);
        bus.wb_addr = 4'd2; bus.wb_data = 32'h2;
        tick();
        bus.wb_en = 1'b0;

        // ADD rd=3, r1, r2
        drive(5'd1, 4'd1, 4'd2, 4'd3, 1'b0, 32'd0);
        #1 check("add1_ready", 32'(bus.in_ready), 32'd1);
        tick();
        bus.in_valid = 1'b0;
        check("add1_valid", 32'(bus.out_valid), 32'd1);
        check("add1_rs1", bus.rs1, 32'h1);
        check("add1_rs2", bus.rs2, 32'h2);
        check("add1_opcode", 32'(bus.Opcode), 32'd1);
        check("add1_rd", 32'(bus.out_rd_addr), 32'd3);

        // SUB rd=5 then SLL reading r5: stalls until r5 is written back
        drive(5'd2, 4'd1, 4'd2, 4'd5, 1'b0, 32'd0);
        #1 check("sub_ready", 32'(bus.in_ready), 32'd1);
        tick();
        drive(5'd3, 4'd5, 4'd2, 4'd6, 1'b0, 32'd0);
        #1 check("sll_stall_inflight", 32'(bus.in_ready), 32'd0);
        tick();
        check("sub_issued", 32'(bus.out_valid), 32'd0);
        check("sll_stall_pending", 32'(bus.in_ready), 32'd0);
        tick();
        check("sll_stall_pending2", 32'(bus.in_ready), 32'd0);
        bus.wb_en = 1'b1; bus.wb_addr = 4'd5; bus.wb_data = 32'h3;
`ifdef FWD_BYPASS_EN
        #1 check("sll_wb_cycle_ready", 32'(bus.in_ready), 32'd1);
`else
        #1 check("sll_wb_cycle_ready", 32'(bus.in_ready), 32'd0);
`endif
        tick();
        bus.wb_en = 1'b0;
`ifndef FWD_BYPASS_EN
        #1 check("sll_post_wb_ready", 32'(bus.in_ready), 32'd1);
        tick();
`endif
        check("sll_valid", 32'(bus.out_valid), 32'd1);
        check("sll_rs1", bus.rs1, 32'h3);
        check("sll_rs2", bus.rs2, 32'h2);
        check("sll_opcode", 32'(bus.Opcode), 32'd3);
        check("sll_rd", 32'(bus.out_rd_addr), 32'd6);

        // r6 in flight: register rs2 stalls, immediate rs2 does not
        drive(5'd1, 4'd1, 4'd6, 4'd0, 1'b0, 32'd0);
        #1 check("rs2_pending_stall", 32'(bus.in_ready), 32'd0);
        drive(5'd4, 4'd1, 4'd6, 4'd0, 1'b1, 32'h2);
        #1 check("imm_no_stall", 32'(bus.in_ready), 32'd1);
        tick();
        check("sltu_rs1", bus.rs1, 32'h1);
        check("sltu_rs2", bus.rs2, 32'h2);
        check("sltu_opcode", 32'(bus.Opcode), 32'd4);

        // Backpressure: payload held, no acceptance
        bus.out_ready = 1'b0;
        drive(5'd1, 4'd2, 4'd1, 4'd0, 1'b0, 32'd0);
        #1 check("bp_ready0", 32'(bus.in_ready), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("bp_valid", 32'(bus.out_valid), 32'd1);
            check("bp_rs1", bus.rs1, 32'h1);
            check("bp_rs2", bus.rs2, 32'h2);
            check("bp_opcode", 32'(bus.Opcode), 32'd4);
            check("bp_ready", 32'(bus.in_ready), 32'd0);
        end
        bus.out_ready = 1'b1;
        #1 check("bp_release_ready", 32'(bus.in_ready), 32'd1);
        tick();
        check("b2b0_valid", 32'(bus.out_valid), 32'd1);
        check("b2b0_rs1", bus.rs1, 32'h2);
        check("b2b0_rs2", bus.rs2, 32'h1);
        check("b2b0_opcode", 32'(bus.Opcode), 32'd1);
        drive(5'd2, 4'd1, 4'd1, 4'd0, 1'b0, 32'd0);
        #1 check("b2b1_ready", 32'(bus.in_ready), 32'd1);
        tick();
        check("b2b1_valid", 32'(bus.out_valid), 32'd1);
        check("b2b1_rs1", bus.rs1, 32'h1);
        check("b2b1_rs2", bus.rs2, 32'h1);
        check("b2b1_opcode", 32'(bus.Opcode), 32'd2);

        // Make r7 pending with another entry in flight, then reset
        drive(5'd1, 4'd1, 4'd2, 4'd7, 1'b0, 32'd0);
        tick();
        drive(5'd1, 4'd1, 4'd1, 4'd0, 1'b0, 32'd0);
        tick();
        check("pre_rst_valid", 32'(bus.out_valid), 32'd1);
        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        check("mid_rst_valid", 32'(bus.out_valid), 32'd0);
        check("mid_rst_rs1", bus.rs1, 32'd0);
        check("mid_rst_opcode", 32'(bus.Opcode), 32'd0);
        tick();
        rst_n = 1'b1;
        // Write to r0 must be ignored
        bus.wb_en = 1'b1; bus.wb_addr = 4'd0; bus.wb_data = 32'hDEAD;
        tick();
        bus.wb_en = 1'b0;
        drive(5'd1, 4'd7, 4'd0, 4'd0, 1'b0, 32'd0);
        #1 check("r7_no_stall", 32'(bus.in_ready), 32'd1);
        tick();
        bus.in_valid = 1'b0;
        check("r7_valid", 32'(bus.out_valid), 32'd1);
        check("r7_rs1", bus.rs1, 32'd0);
        check("r0_rs2", bus.rs2, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
